// File: rtl/if_id_fetch_ctrl.sv
// ============================================================================
// if_id_fetch_ctrl
//
// Instruction-fetch stage control with the IF/ID pipeline register and a
// HALT drain sequencer.
//
// The PC advances by 4, is redirected by a taken branch (flush) or by a jump,
// or holds on a hazard stall. The IF/ID register loads the fetched instruction
// with its PC+4, or a bubble (NOP, valid=0) when the fetched slot is squashed.
// When HALT reaches ID, fetch stops. After DRAIN_CYCLES enabled cycles the
// older instructions have left EX/MEM/WB and o_halted rises. It stays high
// until reset.
//
// Parameters:
//   NBITS        - PC / instruction width
//   PC_RESET     - PC value after reset
//   DRAIN_CYCLES - enabled cycles from HALT leaving ID until the pipeline is empty
//
// Ports:
//   i_clk          rising-edge clock
//   i_reset_n      asynchronous active-low reset
//   i_enable       debug step/run gate; 0 freezes all state
//   i_PC_Write     hazard unit: PC may advance
//   i_IF_ID_Write  hazard unit: IF/ID may load
//   i_IF_ID_Flush  taken branch resolved downstream; squash IF/ID
//   i_branch_addr  branch target
//   i_jump         jump decoded in ID
//   i_jump_addr    jump/JALR target
//   i_HALT         HALT decoded in ID
//   i_instr        instruction read at o_pc (combinational memory)
//   o_pc           fetch address
//   o_IF_ID_instr  latched instruction to ID
//   o_IF_ID_pc4    latched PC+4 to ID
//   o_IF_ID_valid  latched instruction is real (0 = bubble)
//   o_halted       pipeline drained after HALT
//   o_state        FSM state: 0 RUN, 1 DRAIN, 2 HALTED
// ============================================================================
module if_id_fetch_ctrl #(
    parameter int               NBITS        = 32,
    parameter logic [NBITS-1:0] PC_RESET     = '0,
    parameter int               DRAIN_CYCLES = 3
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_enable,
    input  logic             i_PC_Write,
    input  logic             i_IF_ID_Write,
    input  logic             i_IF_ID_Flush,
    input  logic [NBITS-1:0] i_branch_addr,
    input  logic             i_jump,
    input  logic [NBITS-1:0] i_jump_addr,
    input  logic             i_HALT,
    input  logic [NBITS-1:0] i_instr,
    output logic [NBITS-1:0] o_pc,
    output logic [NBITS-1:0] o_IF_ID_instr,
    output logic [NBITS-1:0] o_IF_ID_pc4,
    output logic             o_IF_ID_valid,
    output logic             o_halted,
    output logic [1:0]       o_state
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    localparam int CW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [NBITS-1:0] r_pc;
    logic [NBITS-1:0] r_ifid_instr;
    logic [NBITS-1:0] r_ifid_pc4;
    logic             r_ifid_valid;
    logic             r_halted;

    logic [NBITS-1:0] w_pc4;
    logic [NBITS-1:0] w_branch_tgt;
    logic [NBITS-1:0] w_jump_tgt;
    logic             w_jump_taken;

    // PC+4 wraps naturally at the top of the address space.
    assign w_pc4        = r_pc + NBITS'(4);
    // Targets are forced word-aligned.
    assign w_branch_tgt = i_branch_addr & ~NBITS'(3);
    assign w_jump_tgt   = i_jump_addr & ~NBITS'(3);
    // A jump seen during a PC stall is not taken; it retries next cycle.
    assign w_jump_taken = i_jump & i_PC_Write;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state      <= ST_RUN;
            r_cnt        <= '0;
            r_pc         <= PC_RESET;
            r_ifid_instr <= '0;
            r_ifid_pc4   <= '0;
            r_ifid_valid <= 1'b0;
            r_halted     <= 1'b0;
        end else if (i_enable) begin
            case (r_state)
                ST_RUN: begin
                    // A HALT that coincides with a flush sits on the wrong
                    // path and is squashed, so the flush takes precedence.
                    // The fetch slot after a real HALT is dropped and the PC
                    // freezes at the address after the HALT.
                    if (i_HALT && !i_IF_ID_Flush) begin
                        r_state      <= ST_DRAIN;
                        r_cnt        <= CW'(DRAIN_CYCLES);
                        r_ifid_instr <= '0;
                        r_ifid_pc4   <= '0;
                        r_ifid_valid <= 1'b0;
                    end else begin
                        if (i_IF_ID_Flush) begin
                            r_pc <= w_branch_tgt;
                        end else if (w_jump_taken) begin
                            r_pc <= w_jump_tgt;
                        end else if (i_PC_Write) begin
                            r_pc <= w_pc4;
                        end

                        if (i_IF_ID_Flush || w_jump_taken) begin
                            r_ifid_instr <= '0;
                            r_ifid_pc4   <= '0;
                            r_ifid_valid <= 1'b0;
                        end else if (i_IF_ID_Write) begin
                            r_ifid_instr <= i_instr;
                            r_ifid_pc4   <= w_pc4;
                            r_ifid_valid <= 1'b1;
                        end
                    end
                end

                ST_DRAIN: begin
                    r_ifid_instr <= '0;
                    r_ifid_pc4   <= '0;
                    r_ifid_valid <= 1'b0;
                    // Compare with <= so that a zero-length drain cannot
                    // stay in DRAIN forever.
                    if (r_cnt <= CW'(1)) begin
                        r_state  <= ST_HALTED;
                        r_cnt    <= '0;
                        r_halted <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end

                ST_HALTED: begin
                    r_halted <= 1'b1;
                end

                default: begin
                    r_state <= ST_RUN;
                end
            endcase
        end
    end

    assign o_pc          = r_pc;
    assign o_IF_ID_instr = r_ifid_instr;
    assign o_IF_ID_pc4   = r_ifid_pc4;
    assign o_IF_ID_valid = r_ifid_valid;
    assign o_halted      = r_halted;
    assign o_state       = r_state;

endmodule

// File: doc/if_id_fetch_ctrl.md
IF_ID_FETCH_CTRL -- requirements
Module: if_id_fetch_ctrl

Interface
REQ-001 SHALL have parameter NBITS, default 32, PC and instruction width.
REQ-002 SHALL have parameter PC_RESET, default 0, PC value after reset.
REQ-003 SHALL have parameter DRAIN_CYCLES, default 3, cycles from HALT leaving ID until the pipeline is empty (EX, MEM, WB).
REQ-004 SHALL use one clock; reset is asynchronous and active-low.
REQ-005 i_clk  input  1  rising-edge clock.
REQ-006 i_reset_n  input  1  asynchronous active-low reset.
REQ-007 i_enable  input  1  debug step/run gate; 0 freezes all state.
REQ-008 i_PC_Write  input  1  hazard unit: 1 = PC may advance.
REQ-009 i_IF_ID_Write  input  1  hazard unit: 1 = IF/ID may load.
REQ-010 i_IF_ID_Flush  input  1  taken branch resolved downstream; squash IF/ID.
REQ-011 i_branch_addr  input  NBITS  branch target.
REQ-012 i_jump  input  1  jump decoded in ID.
REQ-013 i_jump_addr  input  NBITS  jump/JALR target.
REQ-014 i_HALT  input  1  HALT decoded in ID.
REQ-015 i_instr  input  NBITS  instruction read at o_pc (combinational memory).
REQ-016 o_pc  output  NBITS  fetch address.
REQ-017 o_IF_ID_instr  output  NBITS  latched instruction to ID.
REQ-018 o_IF_ID_pc4  output  NBITS  latched PC+4 to ID.
REQ-019 o_IF_ID_valid  output  1  1 = latched instruction is real, 0 = bubble.
REQ-020 o_halted  output  1  pipeline drained after HALT.
REQ-021 o_state  output  2  FSM state: 0 RUN, 1 DRAIN, 2 HALTED.

Function
REQ-022 SHALL perform no state change in any cycle with i_enable=0.
REQ-023 SHALL, in RUN with i_enable=1, update PC by priority: i_IF_ID_Flush -> i_branch_addr; else i_jump and i_PC_Write -> i_jump_addr; else i_PC_Write -> o_pc+4; else hold.
REQ-024 SHALL ignore i_jump while i_PC_Write=0 (stalled jump retries next cycle).
REQ-025 SHALL force bits [1:0] of loaded branch/jump targets to 0.
REQ-026 SHALL compute PC+4 modulo 2^NBITS (0xFFFFFFFC wraps to 0x00000000).
REQ-027 SHALL, in RUN with i_enable=1, load IF/ID by priority: i_IF_ID_Flush or taken jump -> instr 0 (NOP), pc4 0, valid 0; else i_IF_ID_Write -> i_instr, o_pc+4, valid 1; else hold.
REQ-028 SHALL transition RUN->DRAIN when i_enable=1, i_HALT=1, i_IF_ID_Flush=0; counter loads DRAIN_CYCLES.
REQ-029 SHALL stay in RUN when i_HALT and i_IF_ID_Flush coincide (squashed HALT).
REQ-030 SHALL, in DRAIN, hold PC, load NOP/valid 0 into IF/ID, decrement counter on each enabled cycle.
REQ-031 SHALL transition DRAIN->HALTED on the enabled cycle the counter equals 1; o_halted=1 from the next edge.
REQ-032 SHALL keep HALTED until reset; PC and IF/ID hold; all hazard/branch/jump inputs ignored in DRAIN and HALTED.
REQ-033 SHALL drive all outputs directly from registers (no combinational input-to-output path).

Reset
REQ-034 SHALL, on i_reset_n=0, immediately set o_pc=PC_RESET, o_IF_ID_instr=0, o_IF_ID_pc4=0, o_IF_ID_valid=0, o_halted=0, state RUN, counter 0.
REQ-035 SHALL, on reset asserted mid-DRAIN or in HALTED, return to RUN with REQ-034 values.
REQ-036 SHALL begin fetching on the first rising edge after i_reset_n rises with i_enable=1.

Verification
REQ-037 Reset, enable=1, PC_Write=IF_ID_Write=1, i_instr=0x8C010000 -> o_pc 0,4,8; o_IF_ID_pc4=4, instr 0x8C010000, valid 1 after first edge.
REQ-038 PC_Write=IF_ID_Write=0 for 1 cycle at o_pc=8 -> o_pc stays 8, IF/ID unchanged, resumes 12 next cycle.
REQ-039 Flush=1, branch_addr=0x43, simultaneous PC_Write=0 -> o_pc=0x40, IF/ID valid 0, instr 0.
REQ-040 jump=1, jump_addr=0x100 with PC_Write=0 then 1 -> PC unchanged first cycle, 0x100 second, IF/ID bubble.
REQ-041 HALT=1 at o_pc=0x20 -> state DRAIN 3 cycles, o_halted=1 on 4th edge, o_pc stays 0x20; enable=0 mid-drain stretches count; HALT with Flush -> stays RUN.
REQ-042 PC=0xFFFFFFFC, PC_Write=1 -> o_pc=0x00000000; reset during HALTED -> o_pc=PC_RESET, o_halted=0.
